// File: rtl/instruction_memory_sync.sv
// Synchronous-read instruction memory for the fetch stage: valid/ready fetch port,
// one-entry backpressurable response register, NOP fill after reset, run-time program port.
module instruction_memory_sync #(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [PC_WIDTH-1:0]        req_pc,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_instr,
  output logic [PC_WIDTH-1:0]        rsp_pc,
  output logic [1:0]                 rsp_fault,
  input  logic                       flush,
  input  logic                       prog_en,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [31:0]                prog_data,
  output logic                       init_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned UW = PC_WIDTH - 2;

  localparam logic [1:0] FAULT_OK        = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
  localparam logic [1:0] FAULT_RANGE     = 2'b10;

  typedef enum logic {INIT, RUN} state_t;

  state_t        state;
  logic [AW-1:0] fill_cnt;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [1:0]    fault;
  logic [AW-1:0] rd_idx;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  // A held response blocks new fetches unless it drains or is flushed this cycle
  assign req_ready = (state == RUN) && !prog_en && (!rsp_valid || rsp_ready || flush);
  assign accept    = req_valid && req_ready;
  assign rd_idx    = req_pc[2 +: AW];

  // Misalignment wins over range
  always_comb begin
    fault = FAULT_OK;
    if (req_pc[1:0] != 2'b00) begin
      fault = FAULT_MISALIGN;
    end else if (req_pc[PC_WIDTH-1:2] >= UW'(DEPTH)) begin
      fault = FAULT_RANGE;
    end
  end

  // Single write port shared between the reset fill and the program port
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = fill_cnt;
    mem_wdata = NOP_WORD;
    if (rst_n) begin
      if (state == INIT) begin
        mem_we = 1'b1;
      end else if (prog_en) begin
        mem_we    = 1'b1;
        mem_waddr = prog_addr;
        mem_wdata = prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // INIT/RUN control: sweep every word once, then open the fetch port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      fill_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          fill_cnt <= fill_cnt + AW'(1);
          if (fill_cnt == AW'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Response register; holds stable while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP_WORD;
      rsp_pc    <= '0;
      rsp_fault <= FAULT_OK;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_pc    <= req_pc;
      rsp_fault <= fault;
      rsp_instr <= (fault == FAULT_OK) ? mem[rd_idx] : NOP_WORD;
    end else if (rsp_ready || flush) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync: reset fill, program/fetch, backpressure,
// faults, flush/program interactions and reset during a pending response.
module tb_instruction_memory_sync;

  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned DEPTH    = 64;
  localparam int unsigned AW       = 6;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [PC_WIDTH-1:0] req_pc;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_instr;
  logic [PC_WIDTH-1:0] rsp_pc;
  logic [1:0]          rsp_fault;
  logic                flush;
  logic                prog_en;
  logic [AW-1:0]       prog_addr;
  logic [31:0]         prog_data;
  logic                init_done;

  int checks   = 0;
  int failures = 0;

  instruction_memory_sync #(
    .PC_WIDTH (PC_WIDTH),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .prog_en   (prog_en),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle before sampling or driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b1;
    flush = 1'b0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    step(); step();
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || rsp_instr !== NOP ||
        rsp_pc !== '0 || rsp_fault !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: valid=%b done=%b instr=%h pc=%h fault=%b, want 0 0 %h 0 00",
               rsp_valid, init_done, rsp_instr, rsp_pc, rsp_fault, NOP);
    end
    rst_n = 1'b1;
    req_valid = 1'b1; req_pc = 32'h0;
    for (int i = 1; i < DEPTH; i++) begin
      step();
      checks++;
      if (init_done !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL init_busy[%0d]: done=%b ready=%b, want 0 0", i, init_done, req_ready);
      end
    end
    step();
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL init_end: done=%b ready=%b, want 1 1", init_done, req_ready);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_instr !== NOP || rsp_fault !== 2'b00 || rsp_pc !== 32'h0) begin
      failures++;
      $display("FAIL fetch_after_fill: valid=%b instr=%h fault=%b pc=%h, want 1 %h 00 0",
               rsp_valid, rsp_instr, rsp_fault, rsp_pc, NOP);
    end
    step();
  endtask

  task automatic test_prog_fetch();
    logic [31:0] words [3];
    words[0] = 32'h00100093; words[1] = 32'h00200113; words[2] = 32'h002081B3;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prog_en = 1'b1; prog_addr = AW'(i + 1); prog_data = words[i];
      step();
    end
    prog_en = 1'b0;
    req_valid = 1'b1; req_pc = 32'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2) req_pc = 32'(4 * (i + 2));
      else req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== words[i] || rsp_pc !== 32'(4 * (i + 1)) ||
          rsp_fault !== 2'b00) begin
        failures++;
        $display("FAIL b2b_fetch[%0d]: valid=%b instr=%h pc=%h fault=%b, want 1 %h %h 00",
                 i, rsp_valid, rsp_instr, rsp_pc, rsp_fault, words[i], 32'(4 * (i + 1)));
      end
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h4;
    step();
    req_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_instr !== 32'h00100093 ||
          rsp_pc !== 32'h4 || rsp_fault !== 2'b00) begin
        failures++;
        $display("FAIL stall_hold[%0d]: ready=%b valid=%b instr=%h pc=%h, want 0 1 00100093 4",
                 i, req_ready, rsp_valid, rsp_instr, rsp_pc);
      end
      if (i < 2) step();
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ready: ready=%b, want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_pc !== 32'h8 || rsp_instr !== 32'h00200113) begin
      failures++;
      $display("FAIL stall_next_fetch: valid=%b pc=%h instr=%h, want 1 8 00200113",
               rsp_valid, rsp_pc, rsp_instr);
    end
    step();
  endtask

  task automatic test_faults();
    logic [31:0] pcs [4];
    logic [1:0]  flt [4];
    pcs[0] = 32'h6;   flt[0] = 2'b01;
    pcs[1] = 32'h100; flt[1] = 2'b10;
    pcs[2] = 32'h102; flt[2] = 2'b01;
    pcs[3] = 32'hFC;  flt[3] = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_pc = pcs[i];
      step();
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_fault !== flt[i] || rsp_instr !== NOP || rsp_pc !== pcs[i]) begin
        failures++;
        $display("FAIL fault[%h]: valid=%b fault=%b instr=%h pc=%h, want 1 %b %h %h",
                 pcs[i], rsp_valid, rsp_fault, rsp_instr, rsp_pc, flt[i], NOP, pcs[i]);
      end
    end
    step();
  endtask

  task automatic test_flush_prog();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h4;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1; req_valid = 1'b1; req_pc = 32'h8;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_ready: ready=%b, want 1", req_ready);
    end
    step();
    flush = 1'b0; req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_pc !== 32'h8 || rsp_instr !== 32'h00200113) begin
      failures++;
      $display("FAIL flush_with_accept: valid=%b pc=%h instr=%h, want 1 8 00200113",
               rsp_valid, rsp_pc, rsp_instr);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_alone: valid=%b, want 0", rsp_valid);
    end
    rsp_ready = 1'b1;
    prog_en = 1'b1; prog_addr = AW'(5); prog_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_pc = 32'h14;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL prog_blocks_ready: ready=%b, want 0", req_ready);
    end
    step();
    prog_en = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL prog_no_accept: valid=%b, want 0", rsp_valid);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'hDEADBEEF || rsp_pc !== 32'h14) begin
      failures++;
      $display("FAIL write_then_read: valid=%b instr=%h pc=%h, want 1 deadbeef 14",
               rsp_valid, rsp_instr, rsp_pc);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_pc = 32'h4;
    step();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pending: valid=%b, want 1", rsp_valid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || rsp_instr !== NOP || rsp_pc !== '0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b done=%b instr=%h pc=%h, want 0 0 %h 0",
               rsp_valid, init_done, rsp_instr, rsp_pc, NOP);
    end
    rsp_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      // A late program write during the fill must be ignored
      prog_en = (i == 60); prog_addr = '0; prog_data = 32'h0BAD0BAD;
      step();
    end
    prog_en = 1'b0;
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL mid_refill_done: done=%b, want 1", init_done);
    end
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_pc = (i == 0) ? 32'h4 : ((i == 1) ? 32'h14 : 32'h0);
      step();
      req_valid = 1'b0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_instr !== NOP || rsp_fault !== 2'b00) begin
        failures++;
        $display("FAIL refill_readback[%h]: valid=%b instr=%h fault=%b, want 1 %h 00",
                 req_pc, rsp_valid, rsp_instr, rsp_fault, NOP);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_prog_fetch();
    test_backpressure();
    test_faults();
    test_flush_prog();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_memory_sync.md
# instruction_memory_sync

Parametrised, synchronous-read instruction memory for the single-cycle core's fetch stage, replacing the combinational ROM. It accepts fetch requests over a valid/ready handshake and returns the instruction one cycle later through a backpressurable output register. After reset it sweeps the whole array with NOPs, then accepts run-time program loads through a dedicated write port. Misaligned and out-of-range fetches are flagged instead of wrapping silently.

## Interface
- `PC_WIDTH`, 32: width of the fetch and program byte addresses.
- `DEPTH`, 64: number of 32-bit words; power of two, 4..4096.
- `NOP_WORD`, 32'h00000013: fill value after reset and the instruction returned on a fault.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  fetch request present.
- `req_ready`  out  1  request accepted on the edge where `req_valid && req_ready`.
- `req_pc`  in  PC_WIDTH  byte address of the fetch.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer takes the response on the edge where `rsp_valid && rsp_ready`.
- `rsp_instr`  out  32  fetched instruction, or `NOP_WORD` on a fault.
- `rsp_pc`  out  PC_WIDTH  `req_pc` of the accepted request.
- `rsp_fault`  out  2  00 ok, 01 misaligned, 10 out of range.
- `flush`  in  1  discard the held response (branch redirect).
- `prog_en`  in  1  program write strobe.
- `prog_addr`  in  log2(DEPTH)  word index for the write.
- `prog_data`  in  32  word to write.
- `init_done`  out  1  high once the reset fill has completed.

## Operation
- FSM has two states: INIT and RUN.
- Reset (`rst_n` low at an edge): state becomes INIT, fill counter 0, `rsp_valid`=0, `rsp_instr`=`NOP_WORD`, `rsp_pc`=0, `rsp_fault`=00, `init_done`=0. Reset overrides every other input, including during INIT or while a response is pending.
- INIT: each cycle writes `NOP_WORD` to word[counter] and increments the counter. After word DEPTH-1 is written, the FSM goes to RUN and `init_done` goes to 1. During INIT, `req_ready`=0 and `prog_en` is ignored.
- RUN: `req_ready` = `!prog_en && (!rsp_valid || rsp_ready || flush)`.
- Fault decode on an accepted request:
  - `req_pc[1:0]`≠0 gives fault 01. This has priority over range.
  - Otherwise, if `req_pc[PC_WIDTH-1:2]` ≥ DEPTH, fault 10.
  - On any fault, `rsp_instr`=`NOP_WORD` and the array is not read.
- Valid request: `rsp_instr` = word[`req_pc[2+:log2(DEPTH)]`].
- Response register (`rsp_valid`, `rsp_instr`, `rsp_pc`, `rsp_fault`):
  - On accept: loaded and `rsp_valid`=1.
  - Otherwise, `rsp_valid` clears when it is consumed or when `flush` is high.
  - While `rsp_valid && !rsp_ready && !flush`, all response outputs hold stable.
- `flush` with an accept in the same cycle: the old response is dropped and the new one is loaded. `flush` alone: `rsp_valid` becomes 0 next edge.
- Program write (RUN, `prog_en`=1): word[`prog_addr`] = `prog_data` at the edge. No fetch is accepted that cycle. A response already held still drains normally. A fetch accepted on a later edge sees the new data.

## Timing
- Fetch latency is 1 cycle: accept at edge N puts valid data on the outputs after edge N.
- Full throughput: with `rsp_ready` held at 1, one fetch per cycle.
- Backpressure: `req_ready` falls combinationally with `rsp_valid && !rsp_ready`. There is no skid entry.
- INIT lasts exactly DEPTH cycles after the first edge with `rst_n`=1. `init_done` rises on that DEPTH-th edge.
- Write-to-read: a write at edge N is visible to a request accepted at edge N+1.
- Array has a single port: write and read are never accepted in the same cycle.

## Test plan
- Reset fill: `rst_n` low 2 cycles, then high. Expect `req_ready`=0 and `init_done`=0 for 64 cycles (DEPTH=64), then both 1. A fetch of pc 0x0 returns 0x00000013, fault 00.
- Program then fetch: write 0x00100093→idx1, 0x00200113→idx2, 0x002081B3→idx3. Back-to-back fetches of 0x4, 0x8, 0xC with `rsp_ready`=1 return those words on consecutive cycles, `rsp_pc` matching.
- Backpressure: accept pc 0x4, hold `rsp_ready`=0 for 3 cycles. Expect `req_ready`=0 and outputs stable at 0x00100093. Raise `rsp_ready`: `req_ready`=1 in the same cycle, and the next fetch is accepted.
- Faults: pc 0x6 gives fault 01 and instr 0x00000013. pc 0x100 (index 64) gives fault 10 and instr 0x00000013. pc 0x102 gives fault 01.
- Flush/simultaneity:
  - Response pending with `rsp_ready`=0: `flush` and a request for 0x8 together leave the 0x8 response valid next cycle, with the old response gone.
  - `prog_en` with `req_valid` gives `req_ready`=0 and the write lands.
- Reset mid-run: `rst_n` low while `rsp_valid`=1 gives `rsp_valid`=0 next edge, INIT restarts, and after 64 cycles previously programmed words read back as 0x00000013.
